// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index and sequencer-state definitions for the ALU command sequencer.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        DIV = 4'd3,
        MOD = 4'd4,
        AND = 4'd5,
        OR  = 4'd6,
        XOR = 4'd7,
        SHL = 4'd8,
        SHR = 4'd9
    } alu_op_e;

    localparam logic [3:0] OP_LAST = 4'd9;

    localparam int F_ERR   = 4;
    localparam int F_NEG   = 3;
    localparam int F_ZERO  = 2;
    localparam int F_CARRY = 1;
    localparam int F_OVF   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU producing result y and flags {err,neg,zero,carry,ovf}.
module alu
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [3:0]   op_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] y_o,
    output logic [4:0]   f_o
);

    logic [N:0]     sum;
    logic [2*N-1:0] prod;
    logic           carry;
    logic           ovf;
    logic           err;

    always_comb begin
        sum   = '0;
        prod  = '0;
        y_o   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        case (op_i)
            ADD: begin
                sum   = {1'b0, a_i} + {1'b0, b_i};
                y_o   = sum[N-1:0];
                carry = sum[N];
                ovf   = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            SUB: begin
                // carry reports a borrow
                sum   = {1'b0, a_i} - {1'b0, b_i};
                y_o   = sum[N-1:0];
                carry = sum[N];
                ovf   = (a_i[N-1] != b_i[N-1]) && (sum[N-1] != a_i[N-1]);
            end
            MUL: begin
                prod  = {{N{1'b0}}, a_i} * {{N{1'b0}}, b_i};
                y_o   = prod[N-1:0];
                carry = |prod[2*N-1:N];
            end
            DIV: begin
                if (b_i == '0) err = 1'b1;
                else           y_o = a_i / b_i;
            end
            MOD: begin
                if (b_i == '0) err = 1'b1;
                else           y_o = a_i % b_i;
            end
            AND: y_o = a_i & b_i;
            OR:  y_o = a_i | b_i;
            XOR: y_o = a_i ^ b_i;
            SHL: y_o = a_i << b_i;
            SHR: y_o = a_i >> b_i;
            default: ;
        endcase
    end

    assign f_o = {err, y_o[N-1], (y_o == '0), carry, ovf};

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with full/empty flags; push is ignored when full, pop ignored when empty.
module alu_cmd_fifo #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;
    logic         do_push;
    logic         do_pop;

    // extra pointer MSB distinguishes full from empty
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
    assign rd_d    = do_pop  ? rd_q + (AW+1)'(1) : rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time and returns results over valid/ready.
// Define ALU_SEQ_ACC_EN to enable the accumulator-chaining operand path (cmd_use_acc).
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [N-1:0]     cmd_a,
    input  logic [N-1:0]     cmd_b,
    input  logic             cmd_use_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_y,
    output logic [4:0]       res_f,
    output logic             res_illegal,
    output logic             busy,
    output logic             err_sticky,
    input  logic             err_clr,
    output logic [CNT_W-1:0] done_cnt
);

`ifdef ALU_SEQ_ACC_EN
    localparam int EW = 2*N + 5;
`else
    localparam int EW = 2*N + 4;
`endif

    seq_state_e       state_q, state_d;
    logic [EW-1:0]    fifo_din, fifo_dout;
    logic             fifo_full, fifo_empty, pop;
    logic [3:0]       op_q;
    logic [N-1:0]     a_q, b_q, ent_a;
    logic [N-1:0]     alu_y, res_y_q, res_y_d;
    logic [4:0]       alu_f, res_f_q, res_f_d;
    logic             illegal_d, res_illegal_q, err_sticky_q;
    logic [CNT_W-1:0] done_cnt_q;

`ifdef ALU_SEQ_ACC_EN
    logic [N-1:0] acc_q;
    assign fifo_din = {cmd_use_acc, cmd_op, cmd_a, cmd_b};
    assign ent_a    = fifo_dout[EW-1] ? acc_q : fifo_dout[2*N-1:N];
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign fifo_din = {cmd_op, cmd_a, cmd_b};
    assign ent_a    = fifo_dout[2*N-1:N];
`endif

    alu_cmd_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid && cmd_ready),
        .din_i   (fifo_din),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    alu #(.N(N)) u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (b_q),
        .y_o  (alu_y),
        .f_o  (alu_f)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: if (res_ready) begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        illegal_d = (op_q > OP_LAST);
        res_y_d   = alu_y;
        res_f_d   = alu_f;
        if (illegal_d) begin
            res_y_d = '0;
            res_f_d = 5'b10000;
        end else if (alu_f[F_ERR]) begin
            res_y_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_y_q       <= '0;
            res_f_q       <= '0;
            res_illegal_q <= 1'b0;
            err_sticky_q  <= 1'b0;
            done_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                op_q <= fifo_dout[2*N+3:2*N];
                a_q  <= ent_a;
                b_q  <= fifo_dout[N-1:0];
            end
            if (state_q == EXEC) begin
                res_y_q       <= res_y_d;
                res_f_q       <= res_f_d;
                res_illegal_q <= illegal_d;
            end
            // a new error outranks a simultaneous clear
            if (state_q == EXEC && res_f_d[F_ERR]) err_sticky_q <= 1'b1;
            else if (err_clr)                      err_sticky_q <= 1'b0;
            if (state_q == RESP && res_ready) done_cnt_q <= done_cnt_q + CNT_W'(1);
        end
    end

`ifdef ALU_SEQ_ACC_EN
    always_ff @(posedge clk) begin
        if (!rst_n)                acc_q <= '0;
        else if (state_q == EXEC)  acc_q <= res_y_d;
    end
`endif

    assign cmd_ready   = !fifo_full;
    assign res_valid   = (state_q == RESP);
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign res_y       = res_y_q;
    assign res_f       = res_f_q;
    assign res_illegal = res_illegal_q;
    assign err_sticky  = err_sticky_q;
    assign done_cnt    = done_cnt_q;

endmodule
